iq_age_scheduler: RTL and testbench
===================================

Name: iq_age_scheduler

Overview:
Control and scheduling block for one issue queue of QUEUE_SIZE payload slots. It owns the per-slot valid vector and the one-hot head (oldest) and tail (allocation) pointers. It accepts allocations from dispatch and picks the oldest ready slot for issue each cycle. The payload RAM sits outside the block; this block drives its write index and its read one-hot select.

Parameters:
QUEUE_SIZE, 8, number of slots (power of two, >=2)
IDX_W, $clog2(QUEUE_SIZE), width of binary slot index

Ports:
clock  input  1  core clock
reset_n  input  1  asynchronous active-low reset
flush  input  1  pipeline flush; kills all slots
enq_valid  input  1  dispatch offers one instruction
enq_ready  output  1  slot available for allocation
enq_idx  output  IDX_W  binary slot written on enq_fire (payload RAM write address)
slot_rdy  input  QUEUE_SIZE  per-slot operands-ready (wakeup result); ignored where slot not valid
iss_valid  output  1  some valid slot is ready
iss_oh  output  QUEUE_SIZE  one-hot selected slot (payload RAM read select)
iss_ready  input  1  functional unit accepts
valid_vec  output  QUEUE_SIZE  registered slot valid bits
head_oh  output  QUEUE_SIZE  one-hot oldest-slot pointer
tail_oh  output  QUEUE_SIZE  one-hot next allocation slot
count  output  IDX_W+1  number of valid slots

Behaviour:
- Reset (async, reset_n=0):
  - valid_vec=0, head_oh=tail_oh=1 (slot 0), count=0.
  - Hence enq_ready=1, iss_valid=0, iss_oh=0, enq_idx=0.
  - Reset may assert mid-operation; all state returns to these values immediately.
- Fire definitions: enq_fire = enq_valid & enq_ready; iss_fire = iss_valid & iss_ready.
- Allocation:
  - enq_ready = ~valid_vec[tail] & ~flush.
  - enq_idx = binary(tail_oh).
  - On enq_fire, valid_vec[tail] is set at the next edge and tail_oh rotates left by one, wrapping from bit QUEUE_SIZE-1 to bit 0.
  - Slots are never allocated out of order. Holes left by out-of-order issue are reused only when the tail reaches them.
- Age order: circular from head_oh (oldest) up to, but excluding, tail_oh.
- Issue select (combinational from registers and slot_rdy):
  - cand = valid_vec & slot_rdy.
  - iss_oh = first set bit of cand, searching circularly starting at head_oh.
  - iss_valid = |cand & ~flush; iss_oh is forced to 0 when iss_valid=0.
  - On iss_fire, valid_vec[iss_oh] clears at the next edge.
- Latency:
  - An entry enqueued in cycle N is valid and issue-eligible from cycle N+1; never in cycle N.
  - Issue in cycle N frees the slot for enq_ready in cycle N+1.
- Head update, computed on the next-state valid vector nv = valid_vec & ~iss_clr | enq_set:
  - If nv==0: head_next = tail_next (pointers re-align when the queue is empty).
  - Else: head_next = first set bit of nv, searching circularly from the current head_oh.
  - Head therefore skips over holes and always points at the oldest valid slot or equals tail.
- Count: count_next = count + enq_fire - iss_fire. Simultaneous enq and issue leaves count unchanged. count stays within 0..QUEUE_SIZE.
- Full / empty:
  - Full: count==QUEUE_SIZE, which implies valid_vec[tail]=1 and enq_ready=0.
  - enq_ready may also be 0 below full when the tail slot still holds an unissued entry.
  - Empty: count==0, valid_vec==0, head_oh==tail_oh.
- Simultaneous events:
  - Enq and issue in the same cycle always target different slots, because the tail slot is not valid when enq fires.
  - Both updates apply at the same edge.
- Flush (synchronous, highest priority):
  - In the flush cycle: enq_ready=0 and iss_valid=0, so no fire occurs.
  - At the next edge: valid_vec=0, count=0, head_oh=tail_oh=1.
  - Back-to-back flushes hold this state.
- Invariant (assertion): popcount(valid_vec)==count; head_oh and tail_oh are always one-hot.

Test Plan:
- Reset, then enq_valid=1 for 8 cycles with iss_ready=0 -> enq_idx 0..7, count 8, valid_vec=8'hFF, enq_ready=0, head_oh=8'h01, tail_oh=8'h01.
- Fill the queue, set slot_rdy=8'h24 (slots 2 and 5), iss_ready=1 -> iss_oh=8'h04 first cycle, 8'h20 next; valid_vec=8'hDB; head_oh stays 8'h01.
- Full queue, issue slot 0 (oldest) only -> next cycle valid_vec=8'hFE, head_oh=8'h02, enq_ready=1, enq_idx=0; enq then sets bit 0 and tail_oh=8'h02.
- Wrap-around ordering: head at slot 6, valid slots 6, 7, 0, 1, all ready -> iss_oh=8'h40; with slot_rdy=8'h01 only -> iss_oh=8'h01.
- Enq and issue in the same cycle with count=3 -> count stays 3, new slot valid next cycle, issued slot cleared.
- flush asserted with count=5 and enq_valid=1 -> enq_ready=0 and iss_valid=0 that cycle; next cycle valid_vec=0, count=0, head_oh=tail_oh=8'h01. Async reset_n pulse mid-fill -> same reset values immediately.

Source files
------------

// File: rtl/iq_age_scheduler.sv
// iq_age_scheduler: valid vector, head/tail pointers and oldest-ready issue pick for one issue queue.
module iq_age_scheduler #(
  parameter int QUEUE_SIZE = 8,
  parameter int IDX_W = $clog2(QUEUE_SIZE)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  output logic [IDX_W-1:0]      enq_idx,
  input  logic [QUEUE_SIZE-1:0] slot_rdy,
  output logic                  iss_valid,
  output logic [QUEUE_SIZE-1:0] iss_oh,
  input  logic                  iss_ready,
  output logic [QUEUE_SIZE-1:0] valid_vec,
  output logic [QUEUE_SIZE-1:0] head_oh,
  output logic [QUEUE_SIZE-1:0] tail_oh,
  output logic [IDX_W:0]        count
);
  localparam int CW = IDX_W + 1;
  logic [QUEUE_SIZE-1:0] valid_q, valid_d, head_q, head_d, tail_q, tail_d;
  logic [QUEUE_SIZE-1:0] cand, enq_set, iss_clr, nv;
  logic [CW-1:0]         count_q, count_d;
  logic                  enq_fire, iss_fire;
  function automatic logic [QUEUE_SIZE-1:0] lsb(input logic [QUEUE_SIZE-1:0] x);
    return x & (~x + QUEUE_SIZE'(1));
  endfunction
  // Circular first-set search: bits at or above the start pointer win, else wrap to bit 0.
  function automatic logic [QUEUE_SIZE-1:0] pick(input logic [QUEUE_SIZE-1:0] v,
                                                 input logic [QUEUE_SIZE-1:0] s);
    logic [QUEUE_SIZE-1:0] hi;
    hi = v & ~(s - QUEUE_SIZE'(1));
    return (|hi) ? lsb(hi) : lsb(v);
  endfunction
  always_comb begin
    enq_idx = '0;
    for (int i = 0; i < QUEUE_SIZE; i++)
      if (tail_q[i]) enq_idx = enq_idx | IDX_W'(i);
  end
  always_comb begin
    enq_ready = ~|(valid_q & tail_q) & ~flush;
    cand      = valid_q & slot_rdy;
    iss_valid = |cand & ~flush;
    iss_oh    = iss_valid ? pick(cand, head_q) : '0;
    enq_fire  = enq_valid & enq_ready;
    iss_fire  = iss_valid & iss_ready;
    enq_set   = enq_fire ? tail_q : '0;
    iss_clr   = iss_fire ? iss_oh : '0;
    nv        = (valid_q & ~iss_clr) | enq_set;
    tail_d    = flush ? QUEUE_SIZE'(1) : enq_fire ? {tail_q[QUEUE_SIZE-2:0], tail_q[QUEUE_SIZE-1]} : tail_q;
    head_d    = flush ? QUEUE_SIZE'(1) : ~|nv ? tail_d : pick(nv, head_q);
    valid_d   = flush ? '0 : nv;
    count_d   = flush ? '0 : count_q + CW'(enq_fire) - CW'(iss_fire);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      head_q  <= QUEUE_SIZE'(1);
      tail_q  <= QUEUE_SIZE'(1);
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  always @(posedge clock) begin
    if (reset_n) begin
      assert ($countones(valid_q) == int'(count_q));
      assert ($onehot(head_q) && $onehot(tail_q));
    end
  end
  assign valid_vec = valid_q;
  assign head_oh   = head_q;
  assign tail_oh   = tail_q;
  assign count     = count_q;
endmodule

// File: tb/tb_iq_age_scheduler.sv
// tb_iq_age_scheduler: directed vectors with hand-computed expectations for iq_age_scheduler.
module tb_iq_age_scheduler;
  logic       clock = 0, reset_n = 0, flush = 0, enq_valid = 0, iss_ready = 0;
  logic [7:0] slot_rdy = '0;
  logic       enq_ready, iss_valid;
  logic [2:0] enq_idx;
  logic [7:0] iss_oh, valid_vec, head_oh, tail_oh;
  logic [3:0] count;
  int checks = 0, errors = 0;

  iq_age_scheduler dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .enq_valid(enq_valid),
    .enq_ready(enq_ready), .enq_idx(enq_idx), .slot_rdy(slot_rdy), .iss_valid(iss_valid),
    .iss_oh(iss_oh), .iss_ready(iss_ready), .valid_vec(valid_vec), .head_oh(head_oh),
    .tail_oh(tail_oh), .count(count)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_valid", 32'(valid_vec), 32'h00);
    chk("rst_head", 32'(head_oh), 32'h01);
    chk("rst_tail", 32'(tail_oh), 32'h01);
    chk("rst_count", 32'(count), 0);
    chk("rst_enq_ready", 32'(enq_ready), 1);
    chk("rst_iss_valid", 32'(iss_valid), 0);
    chk("rst_iss_oh", 32'(iss_oh), 0);
    chk("rst_enq_idx", 32'(enq_idx), 0);
    @(negedge clock);
    reset_n = 1;
    tick();
    // fill: enq_idx walks 0..7, new entries invisible to issue until the next cycle
    enq_valid = 1;
    slot_rdy = 8'hFF;
    #1;
    chk("fill_iss_same_cycle", 32'(iss_valid), 0);
    for (int i = 0; i < 8; i++) begin
      chk("fill_enq_idx", 32'(enq_idx), 32'(i));
      chk("fill_enq_ready", 32'(enq_ready), 1);
      tick();
      if (i == 0) begin
        chk("fill_iss_next_valid", 32'(iss_valid), 1);
        chk("fill_iss_next_oh", 32'(iss_oh), 32'h01);
      end
    end
    enq_valid = 0;
    slot_rdy = 8'h00;
    #1;
    chk("full_count", 32'(count), 8);
    chk("full_valid", 32'(valid_vec), 32'hFF);
    chk("full_enq_ready", 32'(enq_ready), 0);
    chk("full_head", 32'(head_oh), 32'h01);
    chk("full_tail", 32'(tail_oh), 32'h01);
    // out-of-order issue of slots 2 and 5
    slot_rdy = 8'h24;
    iss_ready = 1;
    #1;
    chk("ooo_iss_oh0", 32'(iss_oh), 32'h04);
    tick();
    chk("ooo_iss_oh1", 32'(iss_oh), 32'h20);
    tick();
    chk("ooo_valid", 32'(valid_vec), 32'hDB);
    chk("ooo_head", 32'(head_oh), 32'h01);
    chk("ooo_count", 32'(count), 6);
    slot_rdy = 8'h08;
    #1;
    chk("iss_slot3", 32'(iss_oh), 32'h08);
    tick();
    chk("pre_flush_count", 32'(count), 5);
    // flush with count=5 and dispatch still offering
    flush = 1;
    enq_valid = 1;
    slot_rdy = 8'hFF;
    #1;
    chk("flush_enq_ready", 32'(enq_ready), 0);
    chk("flush_iss_valid", 32'(iss_valid), 0);
    chk("flush_iss_oh", 32'(iss_oh), 0);
    tick();
    tick();
    flush = 0;
    enq_valid = 0;
    iss_ready = 0;
    slot_rdy = 8'h00;
    #1;
    chk("flush_valid", 32'(valid_vec), 0);
    chk("flush_count", 32'(count), 0);
    chk("flush_head", 32'(head_oh), 32'h01);
    chk("flush_tail", 32'(tail_oh), 32'h01);
    chk("flush_enq_ready_after", 32'(enq_ready), 1);
    // refill, then issue the oldest slot of a full queue
    enq_valid = 1;
    for (int i = 0; i < 8; i++) tick();
    enq_valid = 0;
    slot_rdy = 8'h01;
    iss_ready = 1;
    #1;
    chk("oldest_iss_oh", 32'(iss_oh), 32'h01);
    tick();
    iss_ready = 0;
    slot_rdy = 8'h00;
    #1;
    chk("oldest_valid", 32'(valid_vec), 32'hFE);
    chk("oldest_head", 32'(head_oh), 32'h02);
    chk("oldest_enq_ready", 32'(enq_ready), 1);
    chk("oldest_enq_idx", 32'(enq_idx), 0);
    chk("oldest_count", 32'(count), 7);
    enq_valid = 1;
    tick();
    enq_valid = 0;
    #1;
    chk("reuse_valid", 32'(valid_vec), 32'hFF);
    chk("reuse_tail", 32'(tail_oh), 32'h02);
    chk("reuse_head", 32'(head_oh), 32'h02);
    // drain slots 1..5 in age order to move head to slot 6, then enqueue slot 1
    slot_rdy = 8'h3E;
    iss_ready = 1;
    for (int i = 1; i <= 5; i++) begin
      #1;
      chk("drain_iss_oh", 32'(iss_oh), 32'(1 << i));
      tick();
    end
    iss_ready = 0;
    slot_rdy = 8'h00;
    #1;
    chk("drain_valid", 32'(valid_vec), 32'hC1);
    chk("drain_head", 32'(head_oh), 32'h40);
    enq_valid = 1;
    tick();
    enq_valid = 0;
    #1;
    chk("wrap_valid", 32'(valid_vec), 32'hC3);
    chk("wrap_count", 32'(count), 4);
    slot_rdy = 8'hFF;
    #1;
    chk("wrap_all_rdy", 32'(iss_oh), 32'h40);
    slot_rdy = 8'h01;
    #1;
    chk("wrap_rdy0", 32'(iss_oh), 32'h01);
    slot_rdy = 8'h82;
    #1;
    chk("wrap_rdy17", 32'(iss_oh), 32'h80);
    // issue slot 7 to reach count=3, then simultaneous enq and issue
    iss_ready = 1;
    tick();
    chk("sim_pre_count", 32'(count), 3);
    chk("sim_pre_valid", 32'(valid_vec), 32'h43);
    enq_valid = 1;
    slot_rdy = 8'h40;
    #1;
    chk("sim_enq_ready", 32'(enq_ready), 1);
    chk("sim_enq_idx", 32'(enq_idx), 2);
    chk("sim_iss_oh", 32'(iss_oh), 32'h40);
    tick();
    enq_valid = 0;
    iss_ready = 0;
    slot_rdy = 8'h00;
    #1;
    chk("sim_count", 32'(count), 3);
    chk("sim_valid", 32'(valid_vec), 32'h07);
    chk("sim_head", 32'(head_oh), 32'h01);
    chk("sim_tail", 32'(tail_oh), 32'h08);
    // asynchronous reset mid-fill
    enq_valid = 1;
    tick();
    tick();
    chk("midfill_count", 32'(count), 5);
    reset_n = 0;
    #1;
    chk("arst_valid", 32'(valid_vec), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_head", 32'(head_oh), 32'h01);
    chk("arst_tail", 32'(tail_oh), 32'h01);
    chk("arst_enq_idx", 32'(enq_idx), 0);
    enq_valid = 0;
    @(negedge clock);
    reset_n = 1;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
